writeback_unit: RTL and testbench

Register-file writeback stage of the MIPS CPU: the return path that carries results from the execute/memory side back into the register file. It latches one retiring instruction at a time, chooses ALU result or memory load data, and applies byte/halfword extraction with sign or zero extension. It then issues a single-cycle register-file write. A three-state FSM waits for the data-memory response on loads and back-pressures the pipeline while busy.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/writeback_unit_if.sv | 31 +++
 rtl/load_extender.sv | 29 ++
 rtl/writeback_unit.sv | 71 +++++++
 tb/tb_writeback_unit.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load type encodings and the writeback FSM state type.
package cpu_pkg;

  localparam logic [2:0] LOAD_TYPE_W  = 3'd0;
  localparam logic [2:0] LOAD_TYPE_H  = 3'd1;
  localparam logic [2:0] LOAD_TYPE_HU = 3'd2;
  localparam logic [2:0] LOAD_TYPE_B  = 3'd3;
  localparam logic [2:0] LOAD_TYPE_BU = 3'd4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of the writeback stage's upstream, data-memory and register-file signals.
interface writeback_unit_if;

  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_alu_result;
  logic [4:0]  in_dest;
  logic        in_wb_sel;
  logic [2:0]  in_load_type;
  logic        in_mem_valid;
  logic [31:0] in_mem_data;
  logic        out_rf_we;
  logic [4:0]  out_rf_addr;
  logic [31:0] out_rf_wdata;
  logic        out_busy;

  // Pipeline / memory side that feeds the stage and observes its results
  modport master (
    output in_valid, in_alu_result, in_dest, in_wb_sel, in_load_type,
    output in_mem_valid, in_mem_data,
    input  out_ready, out_rf_we, out_rf_addr, out_rf_wdata, out_busy
  );

  // The writeback stage itself
  modport slave (
    input  in_valid, in_alu_result, in_dest, in_wb_sel, in_load_type,
    input  in_mem_valid, in_mem_data,
    output out_ready, out_rf_we, out_rf_addr, out_rf_wdata, out_busy
  );

endinterface

// File: rtl/load_extender.sv
// Little-endian byte/halfword extraction with sign or zero extension.
// Purely combinational so it can be shared with the data-cache bypass path.
module load_extender
  import cpu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  // Pick the addressed lane, then extend according to the load type
  always_comb begin
    half     = addr[1] ? word[31:16] : word[15:0];
    byte_sel = word[8*addr +: 8];
    result   = word;
    case (load_type)
      LOAD_TYPE_H:  result = {{16{half[15]}}, half};
      LOAD_TYPE_HU: result = {16'h0000, half};
      LOAD_TYPE_B:  result = {{24{byte_sel[7]}}, byte_sel};
      LOAD_TYPE_BU: result = {24'h000000, byte_sel};
      default:      result = word;
    endcase
  end

endmodule

// File: rtl/writeback_unit.sv
// Register-file writeback stage: latches one retiring instruction, waits for
// load data when needed, and issues a single-cycle register-file write.
module writeback_unit
  import cpu_pkg::*;
(
  input  logic             in_clk,
  input  logic             in_rst_n,
  writeback_unit_if.slave  bus
);

  wb_state_t   state;
  wb_state_t   next_state;
  logic [31:0] wdata_q;
  logic [4:0]  dest_q;
  logic [2:0]  type_q;
  logic [31:0] ext_data;
  logic        accept;

  assign accept = (state == IDLE) && bus.in_valid;

  // wdata_q holds the latched ALU result until load data replaces it, so its
  // low bits double as the latched load address for lane selection.
  load_extender u_ext (
    .word      (bus.in_mem_data),
    .addr      (wdata_q[1:0]),
    .load_type (type_q),
    .result    (ext_data)
  );

  // State register
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) state <= IDLE;
    else           state <= next_state;
  end

  // Next-state decode: loads detour through WAIT_MEM, everything ends in one WRITE
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.in_valid) next_state = bus.in_wb_sel ? WAIT_MEM : WRITE;
      WAIT_MEM: if (bus.in_mem_valid) next_state = WRITE;
      WRITE:    next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Instruction latch on acceptance, overwritten by extended load data on response
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      wdata_q <= '0;
      dest_q  <= '0;
      type_q  <= '0;
    end else if (accept) begin
      wdata_q <= bus.in_alu_result;
      dest_q  <= bus.in_dest;
      type_q  <= bus.in_load_type;
    end else if (state == WAIT_MEM && bus.in_mem_valid) begin
      wdata_q <= ext_data;
    end
  end

  // Outputs depend only on state and latched values; register 0 is never written
  always_comb begin
    bus.out_ready    = (state == IDLE);
    bus.out_busy     = (state != IDLE);
    bus.out_rf_we    = (state == WRITE) && (dest_q != 5'd0);
    bus.out_rf_addr  = dest_q;
    bus.out_rf_wdata = wdata_q;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed self-checking bench for writeback_unit.
module tb_writeback_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;
  int   assertCount;
  int   failCount;

  writeback_unit_if bus ();

  writeback_unit dut (
    .in_clk   (clk),
    .in_rst_n (rst_n),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic sel,
                               input logic [31:0] alu, input logic [4:0] dest,
                               input logic [2:0] ltype);
    bus.in_valid      = valid;
    bus.in_wb_sel     = sel;
    bus.in_alu_result = alu;
    bus.in_dest       = dest;
    bus.in_load_type  = ltype;
  endtask

  // Full load transaction with a response in the cycle after acceptance
  task automatic runLoad(input string tag, input logic [1:0] addr,
                         input logic [2:0] ltype, input logic [31:0] data,
                         input logic [31:0] expected);
    applyStimulus(1'b1, 1'b1, {30'h0400_0000, addr}, 5'd12, ltype);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput({tag, "_wait_we"}, {31'b0, bus.out_rf_we}, 32'd0);
    bus.in_mem_valid = 1'b1;
    bus.in_mem_data  = data;
    tick();
    bus.in_mem_valid = 1'b0;
    bus.in_mem_data  = 32'hDEAD_BEEF;
    checkOutput({tag, "_we"}, {31'b0, bus.out_rf_we}, 32'd1);
    checkOutput({tag, "_addr"}, {27'b0, bus.out_rf_addr}, 32'd12);
    checkOutput({tag, "_data"}, bus.out_rf_wdata, expected);
    tick();
    checkOutput({tag, "_ready"}, {31'b0, bus.out_ready}, 32'd1);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst_n       = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    bus.in_mem_valid = 1'b0;
    bus.in_mem_data  = 32'h0;
    tick();

    // Reset values
    checkOutput("rst_ready", {31'b0, bus.out_ready}, 32'd1);
    checkOutput("rst_busy", {31'b0, bus.out_busy}, 32'd0);
    checkOutput("rst_we", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("rst_addr", {27'b0, bus.out_rf_addr}, 32'd0);
    checkOutput("rst_wdata", bus.out_rf_wdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // ALU write: one write pulse, ready again two cycles after acceptance
    applyStimulus(1'b1, 1'b0, 32'h1234_5678, 5'd9, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput("alu_we", {31'b0, bus.out_rf_we}, 32'd1);
    checkOutput("alu_addr", {27'b0, bus.out_rf_addr}, 32'd9);
    checkOutput("alu_data", bus.out_rf_wdata, 32'h1234_5678);
    checkOutput("alu_busy", {31'b0, bus.out_busy}, 32'd1);
    checkOutput("alu_ready_lo", {31'b0, bus.out_ready}, 32'd0);
    tick();
    checkOutput("alu_we_drop", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("alu_ready_hi", {31'b0, bus.out_ready}, 32'd1);

    // Load extraction and extension
    runLoad("lb", 2'b10, LOAD_TYPE_B, 32'h00F0_0000, 32'hFFFF_FFF0);
    runLoad("lbu", 2'b10, LOAD_TYPE_BU, 32'h00F0_0000, 32'h0000_00F0);
    runLoad("lh_hi", 2'b10, LOAD_TYPE_H, 32'h8001_7FFF, 32'hFFFF_8001);
    runLoad("lhu_hi", 2'b10, LOAD_TYPE_HU, 32'h8001_7FFF, 32'h0000_8001);
    runLoad("lh_lo", 2'b00, LOAD_TYPE_H, 32'h8001_7FFF, 32'h0000_7FFF);
    runLoad("lh_a1", 2'b11, LOAD_TYPE_H, 32'h8001_7FFF, 32'hFFFF_8001);
    runLoad("lb_b0", 2'b00, LOAD_TYPE_B, 32'h1122_3384, 32'hFFFF_FF84);
    runLoad("lbu_b3", 2'b11, LOAD_TYPE_BU, 32'hA522_3384, 32'h0000_00A5);
    runLoad("lw", 2'b11, LOAD_TYPE_W, 32'h8001_7FFF, 32'h8001_7FFF);
    runLoad("lw_code7", 2'b01, 3'd7, 32'h8001_7FFF, 32'h8001_7FFF);

    // Memory response in the acceptance cycle is ignored
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, 5'd4, LOAD_TYPE_W);
    bus.in_mem_valid = 1'b1;
    bus.in_mem_data  = 32'h5555_5555;
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    bus.in_mem_valid = 1'b0;
    checkOutput("accmem_we", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("accmem_busy", {31'b0, bus.out_busy}, 32'd1);
    bus.in_mem_valid = 1'b1;
    bus.in_mem_data  = 32'h6666_7777;
    tick();
    bus.in_mem_valid = 1'b0;
    checkOutput("accmem_data", bus.out_rf_wdata, 32'h6666_7777);
    tick();

    // Memory stall with a new instruction offered throughout
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, 5'd20, LOAD_TYPE_W);
    tick();
    applyStimulus(1'b1, 1'b0, 32'hCAFE_0003, 5'd3, 3'd0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall_ready", {31'b0, bus.out_ready}, 32'd0);
      checkOutput("stall_busy", {31'b0, bus.out_busy}, 32'd1);
      checkOutput("stall_we", {31'b0, bus.out_rf_we}, 32'd0);
      tick();
    end
    bus.in_mem_valid = 1'b1;
    bus.in_mem_data  = 32'hA1B2_C3D4;
    tick();
    bus.in_mem_valid = 1'b0;
    checkOutput("stall_wr_we", {31'b0, bus.out_rf_we}, 32'd1);
    checkOutput("stall_wr_addr", {27'b0, bus.out_rf_addr}, 32'd20);
    checkOutput("stall_wr_data", bus.out_rf_wdata, 32'hA1B2_C3D4);
    tick();
    checkOutput("stall_idle_we", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("stall_idle_ready", {31'b0, bus.out_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput("held_we", {31'b0, bus.out_rf_we}, 32'd1);
    checkOutput("held_addr", {27'b0, bus.out_rf_addr}, 32'd3);
    checkOutput("held_data", bus.out_rf_wdata, 32'hCAFE_0003);
    tick();

    // Register 0 is never written
    applyStimulus(1'b1, 1'b0, 32'hFFFF_0000, 5'd0, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput("r0_we", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("r0_busy", {31'b0, bus.out_busy}, 32'd1);
    tick();
    checkOutput("r0_we_after", {31'b0, bus.out_rf_we}, 32'd0);
    checkOutput("r0_ready", {31'b0, bus.out_ready}, 32'd1);

    // Reset mid-load aborts at once and drops the pending response
    applyStimulus(1'b1, 1'b1, 32'h0000_0000, 5'd7, LOAD_TYPE_W);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput("rstmid_busy_pre", {31'b0, bus.out_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_ready", {31'b0, bus.out_ready}, 32'd1);
    checkOutput("rstmid_busy", {31'b0, bus.out_busy}, 32'd0);
    checkOutput("rstmid_addr", {27'b0, bus.out_rf_addr}, 32'd0);
    checkOutput("rstmid_wdata", bus.out_rf_wdata, 32'd0);
    #1;
    rst_n = 1'b1;
    bus.in_mem_valid = 1'b1;
    bus.in_mem_data  = 32'h7777_7777;
    tick();
    checkOutput("rstmid_nowr1", {31'b0, bus.out_rf_we}, 32'd0);
    bus.in_mem_valid = 1'b0;
    tick();
    checkOutput("rstmid_nowr2", {31'b0, bus.out_rf_we}, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0BAD_F00D, 5'd5, 3'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 5'd0, 3'd0);
    checkOutput("post_rst_we", {31'b0, bus.out_rf_we}, 32'd1);
    checkOutput("post_rst_addr", {27'b0, bus.out_rf_addr}, 32'd5);
    checkOutput("post_rst_data", bus.out_rf_wdata, 32'h0BAD_F00D);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
